pcpu_dmem_responder: RTL

//  - Data-memory responder for the PCPU data port (d_addr/d_dataout/d_we in, d_datain out).
//  - Clears its storage after reset, accepts a host preload over a valid/ready port, then serves CPU loads and stores.
//  - Replaces the stimulus-driven d_datain in CPU benches with a real storage model.

---
 rtl/pcpu_dmem_pkg.sv | 21 ++
 rtl/pcpu_dmem_array.sv | 44 ++++
 rtl/pcpu_dmem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pcpu_dmem_pkg.sv
// Shared definitions for the PCPU data-memory responder.
// Contents:
//   dm_state_e  : responder FSM states (CLEAR, LOAD, RUN)
//   DM_CNT_MAX  : saturation value of the access counters
//   dm_sat_inc  : saturating 16-bit increment used by both counters
// Optional feature macro: DMEM_PARITY_EN (see pcpu_dmem_responder).
package pcpu_dmem_pkg;

   typedef enum logic [1:0] {
      DM_CLEAR = 2'b00,
      DM_LOAD  = 2'b01,
      DM_RUN   = 2'b10
   } dm_state_e;

   localparam logic [15:0] DM_CNT_MAX = 16'hFFFF;

   function automatic logic [15:0] dm_sat_inc(input logic [15:0] v);
      return (v == DM_CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pcpu_dmem_array.sv
// Single-write-port storage with synchronous write and a registered read port.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high, clears only the read register
//   we      : write enable; waddr/wdata : write address/data
//   re      : read enable; raddr : read address
//   rdata   : registered read data, holds when re=0
// A simultaneous write and read of the same address returns the new data
// (write-first), so the CPU sees its own store on the same edge.
module pcpu_dmem_array #(
   parameter int AW = 8,
   parameter int WW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [WW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [WW-1:0] mem_q [0:DEPTH-1];
   logic [WW-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re) begin
         if (we && (waddr == raddr)) rdata_q <= wdata;
         else                        rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pcpu_dmem_responder.sv
// Data-memory responder for the PCPU data port.
// After reset it zeroes every word (CLEAR, DEPTH cycles), accepts host
// preload words over ld_valid/ld_ready until ld_done (LOAD), then serves
// CPU loads and stores (RUN) until the next reset.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   enable                : CPU-side enable; low freezes the CPU port
//   d_addr/d_dataout/d_we : CPU address, store data, write enable
//   d_datain              : registered CPU load data (write-first on stores)
//   ld_valid/ld_ready     : host preload handshake (ready only in LOAD)
//   ld_addr/ld_data       : preload address/data
//   ld_done               : host ends preload (1-cycle pulse)
//   mem_ready             : high in RUN
//   rd_count/wr_count     : saturating CPU read/write cycle counters
//   perr                  : sticky parity error, only with DMEM_PARITY_EN
// Configuration macro: DMEM_PARITY_EN adds an even-parity bit per word.
module pcpu_dmem_responder
   import pcpu_dmem_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_dataout,
   input  logic          d_we,
   output logic [DW-1:0] d_datain,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_done,
   output logic          mem_ready,
   output logic [15:0]   rd_count,
`ifdef DMEM_PARITY_EN
   output logic [15:0]   wr_count,
   output logic          perr
`else
   output logic [15:0]   wr_count
`endif
);

`ifdef DMEM_PARITY_EN
   localparam int WW = DW + 1;
`else
   localparam int WW = DW;
`endif
   localparam logic [AW-1:0] PTR_LAST = '1;

   dm_state_e     state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic [15:0]   rd_cnt_q, rd_cnt_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d;

   logic          run, cpu_act;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata_raw;
   logic [WW-1:0] mem_wdata;
   logic [WW-1:0] mem_rdata;

   assign run     = (state_q == DM_RUN);
   assign cpu_act = run && enable;

   // FSM next state and clear pointer
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         DM_CLEAR: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == PTR_LAST) state_d = DM_LOAD;
         end
         DM_LOAD: if (ld_done) state_d = DM_RUN;
         DM_RUN:  state_d = DM_RUN;
         default: state_d = DM_CLEAR;
      endcase
   end

   // Write-port mux: the current state decides who owns the single port
   always_comb begin
      mem_we        = 1'b0;
      mem_waddr     = clr_ptr_q;
      mem_wdata_raw = '0;
      case (state_q)
         DM_CLEAR: mem_we = 1'b1;
         DM_LOAD: begin
            mem_we        = ld_valid;
            mem_waddr     = ld_addr;
            mem_wdata_raw = ld_data;
         end
         DM_RUN: begin
            mem_we        = enable && d_we;
            mem_waddr     = d_addr;
            mem_wdata_raw = d_dataout;
         end
         default: mem_we = 1'b0;
      endcase
   end

`ifdef DMEM_PARITY_EN
   assign mem_wdata = {^mem_wdata_raw, mem_wdata_raw};
`else
   assign mem_wdata = mem_wdata_raw;
`endif

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (cpu_act) begin
         if (d_we) wr_cnt_d = dm_sat_inc(wr_cnt_q);
         else      rd_cnt_d = dm_sat_inc(rd_cnt_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= DM_CLEAR;
         clr_ptr_q <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   pcpu_dmem_array #(.AW(AW), .WW(WW)) u_array (
      .clock (clock),
      .reset (reset),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (cpu_act),
      .raddr (d_addr),
      .rdata (mem_rdata)
   );

`ifdef DMEM_PARITY_EN
   // The read register updates on the access edge; the parity of the
   // returned word is judged one cycle later, only for true CPU reads.
   logic chk_q, perr_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         chk_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         chk_q <= cpu_act && !d_we;
         if (chk_q && (^mem_rdata)) perr_q <= 1'b1;
      end
   end
   assign perr = perr_q;
`endif

   assign d_datain  = mem_rdata[DW-1:0];
   assign ld_ready  = (state_q == DM_LOAD);
   assign mem_ready = run;
   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;

endmodule
